dram_port_arbiter: RTL and testbench
====================================

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter
Interface
REQ-001 SHALL have parameters: ADDR_W default 32 (byte address width); DATA_W default 128 (one cache line per transfer).
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-003 i_rreq_valid  input  1  I-cache refill read request.
REQ-004 i_rreq_ready  output  1  I-cache read request accepted.
REQ-005 i_raddr  input  ADDR_W  I-cache line address.
REQ-006 i_rrep_valid  output  1  I-cache read data valid, one-cycle pulse.
REQ-007 i_rdata  output  DATA_W  I-cache read line.
REQ-008 d_rreq_valid  input  1  D-cache refill read request.
REQ-009 d_rreq_ready  output  1  D-cache read request accepted.
REQ-010 d_raddr  input  ADDR_W  D-cache read line address.
REQ-011 d_rrep_valid  output  1  D-cache read data valid, one-cycle pulse.
REQ-012 d_rdata  output  DATA_W  D-cache read line.
REQ-013 d_wreq_valid  input  1  D-cache writeback request.
REQ-014 d_wreq_ready  output  1  D-cache writeback accepted.
REQ-015 d_waddr  input  ADDR_W  writeback line address.
REQ-016 d_wdata  input  DATA_W  writeback line data.
REQ-017 d_wrep_valid  output  1  writeback complete, one-cycle pulse.
REQ-018 m_rreq_valid  output  1  read request to data DRAM.
REQ-019 m_rreq_ready  input  1  DRAM read request ready.
REQ-020 m_raddr  output  ADDR_W  DRAM read address, low 4 bits forced 0.
REQ-021 m_rrep_valid  input  1  DRAM read reply valid.
REQ-022 m_rdata  input  DATA_W  DRAM read line.
REQ-023 m_wreq_valid  output  1  write request to data DRAM.
REQ-024 m_wreq_ready  input  1  DRAM write request ready.
REQ-025 m_waddr  output  ADDR_W  DRAM write address, low 4 bits forced 0.
REQ-026 m_wdata  output  DATA_W  DRAM write line.
REQ-027 m_wrep_valid  input  1  DRAM write reply valid.
Function
REQ-028 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT; at most one DRAM transaction outstanding.
REQ-029 In IDLE, grant priority SHALL be: D-cache write first; otherwise I-read vs D-read by round-robin on a 1-bit last_rd_owner (the read owner not granted last wins; reset value = I-cache, so D-read wins the first tie).
REQ-030 Only the granted requester's ready SHALL be high, combinationally, in IDLE only; acceptance = valid && ready.
REQ-031 On acceptance, address (low 4 bits zeroed), data, and owner SHALL be latched; next state RD_REQ or WR_REQ; last_rd_owner updates on read grants only.
REQ-032 In RD_REQ/WR_REQ, m_*req_valid SHALL be high with latched address/data, held stable until m_*req_ready; then go to RD_WAIT/WR_WAIT.
REQ-033 In RD_WAIT, on m_rrep_valid the arbiter SHALL pulse the owner's *_rrep_valid in the same cycle with m_rdata passed combinationally; next state IDLE. The non-owner's rrep_valid stays 0.
REQ-034 In WR_WAIT, on m_wrep_valid it SHALL pulse d_wrep_valid in the same cycle; next state IDLE.
REQ-035 m_rrep_valid or m_wrep_valid arriving in any state other than the matching WAIT state SHALL be ignored.
REQ-036 Requests arriving while not IDLE SHALL remain pending (ready=0). Requesters hold valid and payload until accepted. Replies are always accepted.
REQ-037 Best-case round trip, valid to reply, with DRAM ready high and 2-cycle reply: accept in cycle 0, reply pulse in cycle 3.
Reset
REQ-038 rst SHALL force IDLE, last_rd_owner = I-cache, and every ready/valid output to 0; an in-flight transaction is abandoned with no reply pulse, and its late DRAM reply is ignored.
Structure
REQ-039 The FSM state enum, owner enum, and LINE_BYTES = 16 constant SHALL live in a shared package mem_pkg. Round-robin selection SHALL be a sub-module, rr_arb2.
Verification
REQ-040 Single I-read, raddr 0x0000_0123 -> m_raddr = 0x0000_0120, i_rrep_valid pulses once with m_rdata, d_rrep_valid stays 0.
REQ-041 I-read and D-read both valid in the cycle after reset -> D granted first, then I; alternating on repeated ties.
REQ-042 D-write (0x40, data 0xA5 repeated) plus both reads valid -> write granted first, m_wdata matches, d_wrep_valid pulses, then the reads.
REQ-043 m_rreq_ready held 0 for 5 cycles -> m_raddr is stable and no ready is asserted to any requester during the stall.
REQ-044 rst in RD_WAIT -> FSM returns to IDLE, the following m_rrep_valid produces no reply pulse, and the next request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the DRAM port arbiter: FSM states, read-owner tags and line geometry.
package mem_pkg;

  localparam int LINE_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between I-cache and D-cache read requests.
module rr_arb2
  import mem_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_owner,
  output logic   i_grant,
  output logic   d_grant
);

  // On a tie the owner not served last wins; otherwise the lone requester wins.
  always_comb begin
    i_grant = 1'b0;
    d_grant = 1'b0;
    if (i_req && d_req) begin
      if (last_owner == OWNER_I) begin
        d_grant = 1'b1;
      end else begin
        i_grant = 1'b1;
      end
    end else begin
      i_grant = i_req;
      d_grant = d_req;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Single-outstanding arbiter muxing I-cache reads, D-cache reads and D-cache
// writebacks onto one line-wide DRAM port.
module dram_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rreq_valid,
  output logic              i_rreq_ready,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              i_rrep_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_rreq_valid,
  output logic              d_rreq_ready,
  input  logic [ADDR_W-1:0] d_raddr,
  output logic              d_rrep_valid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_wreq_valid,
  output logic              d_wreq_ready,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wrep_valid,
  output logic              m_rreq_valid,
  input  logic              m_rreq_ready,
  output logic [ADDR_W-1:0] m_raddr,
  input  logic              m_rrep_valid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_wreq_valid,
  input  logic              m_wreq_ready,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_wrep_valid
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  arb_state_e        state_r;
  owner_e            last_rd_owner_r;
  owner_e            owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              i_grant_s;
  logic              d_grant_s;
  logic              idle_s;
  logic              rd_reply_s;

  rr_arb2 u_rr_arb2 (
    .i_req      (i_rreq_valid),
    .d_req      (d_rreq_valid),
    .last_owner (last_rd_owner_r),
    .i_grant    (i_grant_s),
    .d_grant    (d_grant_s)
  );

  // Ready and reply strobes are gated by rst so nothing handshakes in the reset cycle.
  always_comb begin
    idle_s       = (state_r == ST_IDLE) && !rst;
    d_wreq_ready = idle_s && d_wreq_valid;
    i_rreq_ready = idle_s && !d_wreq_valid && i_grant_s;
    d_rreq_ready = idle_s && !d_wreq_valid && d_grant_s;
    m_rreq_valid = (state_r == ST_RD_REQ) && !rst;
    m_wreq_valid = (state_r == ST_WR_REQ) && !rst;
    rd_reply_s   = (state_r == ST_RD_WAIT) && m_rrep_valid && !rst;
    i_rrep_valid = rd_reply_s && (owner_r == OWNER_I);
    d_rrep_valid = rd_reply_s && (owner_r == OWNER_D);
    d_wrep_valid = (state_r == ST_WR_WAIT) && m_wrep_valid && !rst;
    i_rdata      = m_rdata;
    d_rdata      = m_rdata;
    m_raddr      = addr_r;
    m_waddr      = addr_r;
    m_wdata      = wdata_r;
  end

  // Transaction FSM; replies outside the matching WAIT state fall through unused.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      last_rd_owner_r <= OWNER_I;
      owner_r         <= OWNER_I;
      addr_r          <= '0;
      wdata_r         <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (d_wreq_valid) begin
            addr_r  <= d_waddr & LINE_MASK;
            wdata_r <= d_wdata;
            state_r <= ST_WR_REQ;
          end else if (i_rreq_ready) begin
            addr_r          <= i_raddr & LINE_MASK;
            owner_r         <= OWNER_I;
            last_rd_owner_r <= OWNER_I;
            state_r         <= ST_RD_REQ;
          end else if (d_rreq_ready) begin
            addr_r          <= d_raddr & LINE_MASK;
            owner_r         <= OWNER_D;
            last_rd_owner_r <= OWNER_D;
            state_r         <= ST_RD_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_REQ:  state_r <= m_rreq_ready ? ST_RD_WAIT : ST_RD_REQ;
        ST_RD_WAIT: state_r <= m_rrep_valid ? ST_IDLE : ST_RD_WAIT;
        ST_WR_REQ:  state_r <= m_wreq_ready ? ST_WR_WAIT : ST_WR_REQ;
        ST_WR_WAIT: state_r <= m_wrep_valid ? ST_IDLE : ST_WR_WAIT;
        default:    state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: the bench plays both caches and the DRAM.
module tb_dram_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_rreq_valid = 1'b0;
  logic              i_rreq_ready;
  logic [ADDR_W-1:0] i_raddr = '0;
  logic              i_rrep_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_rreq_valid = 1'b0;
  logic              d_rreq_ready;
  logic [ADDR_W-1:0] d_raddr = '0;
  logic              d_rrep_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_wreq_valid = 1'b0;
  logic              d_wreq_ready;
  logic [ADDR_W-1:0] d_waddr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_wrep_valid;
  logic              m_rreq_valid;
  logic              m_rreq_ready = 1'b0;
  logic [ADDR_W-1:0] m_raddr;
  logic              m_rrep_valid = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_wreq_valid;
  logic              m_wreq_ready = 1'b0;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wrep_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_rreq_valid(i_rreq_valid), .i_rreq_ready(i_rreq_ready), .i_raddr(i_raddr),
    .i_rrep_valid(i_rrep_valid), .i_rdata(i_rdata),
    .d_rreq_valid(d_rreq_valid), .d_rreq_ready(d_rreq_ready), .d_raddr(d_raddr),
    .d_rrep_valid(d_rrep_valid), .d_rdata(d_rdata),
    .d_wreq_valid(d_wreq_valid), .d_wreq_ready(d_wreq_ready), .d_waddr(d_waddr),
    .d_wdata(d_wdata), .d_wrep_valid(d_wrep_valid),
    .m_rreq_valid(m_rreq_valid), .m_rreq_ready(m_rreq_ready), .m_raddr(m_raddr),
    .m_rrep_valid(m_rrep_valid), .m_rdata(m_rdata),
    .m_wreq_valid(m_wreq_valid), .m_wreq_ready(m_wreq_ready), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wrep_valid(m_wrep_valid)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic ei, input logic ed, input logic ew);
    #1;
    chk({tag, "_i_ready"}, DATA_W'(i_rreq_ready), DATA_W'(ei));
    chk({tag, "_d_ready"}, DATA_W'(d_rreq_ready), DATA_W'(ed));
    chk({tag, "_w_ready"}, DATA_W'(d_wreq_ready), DATA_W'(ew));
  endtask

  // Entered in the low phase right after the read was accepted (FSM in RD_REQ).
  task automatic serve_read(input string tag, input logic [ADDR_W-1:0] exp_addr,
                            input logic [DATA_W-1:0] line, input logic owner_d);
    #1;
    chk({tag, "_mrv"}, DATA_W'(m_rreq_valid), DATA_W'(1'b1));
    chk({tag, "_maddr"}, DATA_W'(m_raddr), DATA_W'(exp_addr));
    chk({tag, "_mwv"}, DATA_W'(m_wreq_valid), DATA_W'(1'b0));
    m_rreq_ready = 1'b1;
    @(negedge clk);
    m_rreq_ready = 1'b0;
    #1;
    chk({tag, "_mrv_wait"}, DATA_W'(m_rreq_valid), DATA_W'(1'b0));
    @(negedge clk);
    m_rrep_valid = 1'b1;
    m_rdata      = line;
    #1;
    chk({tag, "_i_rrep"}, DATA_W'(i_rrep_valid), DATA_W'(!owner_d));
    chk({tag, "_d_rrep"}, DATA_W'(d_rrep_valid), DATA_W'(owner_d));
    chk({tag, "_rdata"}, owner_d ? d_rdata : i_rdata, line);
    @(negedge clk);
    m_rrep_valid = 1'b0;
    #1;
    chk({tag, "_i_rrep_end"}, DATA_W'(i_rrep_valid), DATA_W'(1'b0));
    chk({tag, "_d_rrep_end"}, DATA_W'(d_rrep_valid), DATA_W'(1'b0));
  endtask

  initial begin
    // Reset: pending requests and stray replies must see no ready/valid.
    @(negedge clk);
    i_rreq_valid = 1'b1;
    d_wreq_valid = 1'b1;
    m_rrep_valid = 1'b1;
    m_wrep_valid = 1'b1;
    chk_ready("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_mrv", DATA_W'(m_rreq_valid), DATA_W'(1'b0));
    chk("rst_mwv", DATA_W'(m_wreq_valid), DATA_W'(1'b0));
    chk("rst_i_rrep", DATA_W'(i_rrep_valid), DATA_W'(1'b0));
    chk("rst_wrep", DATA_W'(d_wrep_valid), DATA_W'(1'b0));
    @(negedge clk);
    i_rreq_valid = 1'b0;
    d_wreq_valid = 1'b0;
    m_rrep_valid = 1'b0;
    m_wrep_valid = 1'b0;
    rst = 1'b0;

    // Single I-read with an unaligned address.
    i_rreq_valid = 1'b1;
    i_raddr      = 32'h0000_0123;
    chk_ready("t1", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    i_rreq_valid = 1'b0;
    serve_read("t1", 32'h0000_0120, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1'b0);

    // Fresh reset, then a read tie: D, I, D.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_rreq_valid = 1'b1;
    i_raddr      = 32'h0000_1000;
    d_rreq_valid = 1'b1;
    d_raddr      = 32'h0000_2004;
    chk_ready("t2a", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    d_rreq_valid = 1'b0;
    #1;
    chk("t2a_i_pending", DATA_W'(i_rreq_ready), DATA_W'(1'b0));
    serve_read("t2a", 32'h0000_2000, 128'hd0d0_0001, 1'b1);
    d_rreq_valid = 1'b1;
    d_raddr      = 32'h0000_3000;
    chk_ready("t2b", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    i_rreq_valid = 1'b0;
    serve_read("t2b", 32'h0000_1000, 128'h1111_0002, 1'b0);
    i_rreq_valid = 1'b1;
    i_raddr      = 32'h0000_400f;
    chk_ready("t2c", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    d_rreq_valid = 1'b0;
    serve_read("t2c", 32'h0000_3000, 128'hd0d0_0003, 1'b1);

    // Writeback beats both pending reads; a stray read reply in WR_WAIT is ignored.
    d_wreq_valid = 1'b1;
    d_waddr      = 32'h0000_0040;
    d_wdata      = {16{8'hA5}};
    d_rreq_valid = 1'b1;
    d_raddr      = 32'h0000_0600;
    chk_ready("t3w", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    d_wreq_valid = 1'b0;
    #1;
    chk("t3_mwv", DATA_W'(m_wreq_valid), DATA_W'(1'b1));
    chk("t3_mwaddr", DATA_W'(m_waddr), DATA_W'(32'h0000_0040));
    chk("t3_mwdata", m_wdata, {16{8'hA5}});
    chk("t3_mrv", DATA_W'(m_rreq_valid), DATA_W'(1'b0));
    m_wreq_ready = 1'b1;
    @(negedge clk);
    m_wreq_ready = 1'b0;
    m_rrep_valid = 1'b1;
    #1;
    chk("t3_mwv_wait", DATA_W'(m_wreq_valid), DATA_W'(1'b0));
    chk("t3_stray_i", DATA_W'(i_rrep_valid), DATA_W'(1'b0));
    chk("t3_stray_d", DATA_W'(d_rrep_valid), DATA_W'(1'b0));
    @(negedge clk);
    m_rrep_valid = 1'b0;
    m_wrep_valid = 1'b1;
    #1;
    chk("t3_wrep", DATA_W'(d_wrep_valid), DATA_W'(1'b1));
    @(negedge clk);
    m_wrep_valid = 1'b0;
    #1;
    chk("t3_wrep_end", DATA_W'(d_wrep_valid), DATA_W'(1'b0));
    chk_ready("t3i", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    i_rreq_valid = 1'b0;
    serve_read("t3i", 32'h0000_4000, 128'h1111_0004, 1'b0);
    chk_ready("t3d", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    d_rreq_valid = 1'b0;
    serve_read("t3d", 32'h0000_0600, 128'hd0d0_0005, 1'b1);

    // DRAM stalls the read request for 5 cycles while other requests wait.
    i_rreq_valid = 1'b1;
    i_raddr      = 32'h0000_7008;
    chk_ready("t4", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    i_rreq_valid = 1'b0;
    d_rreq_valid = 1'b1;
    d_raddr      = 32'h0000_7100;
    d_wreq_valid = 1'b1;
    d_waddr      = 32'h0000_7200;
    for (int k = 0; k < 5; k++) begin
      chk_ready("t4_stall", 1'b0, 1'b0, 1'b0);
      chk("t4_stall_addr", DATA_W'(m_raddr), DATA_W'(32'h0000_7000));
      chk("t4_stall_mrv", DATA_W'(m_rreq_valid), DATA_W'(1'b1));
      @(negedge clk);
    end
    serve_read("t4", 32'h0000_7000, 128'h1111_0006, 1'b0);
    chk_ready("t4_after", 1'b0, 1'b0, 1'b1);
    d_rreq_valid = 1'b0;
    d_wreq_valid = 1'b0;

    // Reset while waiting on a read reply: the late reply is dropped.
    d_rreq_valid = 1'b1;
    d_raddr      = 32'h0000_8000;
    chk_ready("t5", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    d_rreq_valid = 1'b0;
    m_rreq_ready = 1'b1;
    @(negedge clk);
    m_rreq_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_d_rrep", DATA_W'(d_rrep_valid), DATA_W'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    m_rrep_valid = 1'b1;
    m_rdata      = 128'hdead_beef;
    #1;
    chk("t5_late_d", DATA_W'(d_rrep_valid), DATA_W'(1'b0));
    chk("t5_late_i", DATA_W'(i_rrep_valid), DATA_W'(1'b0));
    chk("t5_late_mrv", DATA_W'(m_rreq_valid), DATA_W'(1'b0));
    @(negedge clk);
    m_rrep_valid = 1'b0;
    i_rreq_valid = 1'b1;
    i_raddr      = 32'h0000_9004;
    chk_ready("t5n", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    i_rreq_valid = 1'b0;
    serve_read("t5n", 32'h0000_9000, 128'h1111_0007, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
